multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath mux selects, register/memory write enables and the 4-bit `alu_control` code consumed by the ALU. Uses the ALU `zero` flag to resolve branches and handshakes with a variable-latency memory port.

---
 rtl/multicycle_control.sv | 279 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle RV32I core. Steps each
//               instruction through fetch, decode, execute, memory access and
//               writeback, driving datapath mux selects, write enables and the
//               4-bit ALU operation code. Branches resolve from the ALU zero
//               flag; memory states wait on a variable-latency ready.
// Ports       : clk, reset (sync, active-high)
//               instr, zero, mem_ready                    - inputs
//               mem_req, mem_write, adr_src, ir_write,
//               pc_write, reg_write, result_src, alu_src_a,
//               alu_src_b, imm_src, alu_control, state     - outputs
//               illegal                                    - output, only with
//                                                            CTRL_ILLEGAL_TRAP_EN
// Options     : CTRL_ILLEGAL_TRAP_EN - illegal instructions park the FSM in
//               TRAP with a sticky illegal flag; otherwise they act as a NOP.
// Revision    : 1.0 - initial release
//==============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [3:0]  state
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_XOR  = 4'b1010;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1111;
    localparam logic [3:0] c_ALU_SLL  = 4'b1000;
    localparam logic [3:0] c_ALU_SRL  = 4'b1001;
    localparam logic [3:0] c_ALU_SRA  = 4'b0011;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    // Where an illegal opcode or branch funct3 sends the FSM.
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t c_ILLEGAL_DEST = S_TRAP;
`else
    localparam state_t c_ILLEGAL_DEST = S_FETCH;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign state    = r_state;
    // Register fields and most funct7 bits are the datapath's concern.
    assign w_unused = &{1'b0, instr[31], instr[29:15], instr[11:7]};

    // funct3 -> ALU op for register and immediate arithmetic. 'alt' selects
    // SUB/SRA; the caller masks it off for ADDI.
    function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu_op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  f_alu_op = c_ALU_SLL;
            3'b010:  f_alu_op = c_ALU_SLT;
            3'b011:  f_alu_op = c_ALU_SLTU;
            3'b100:  f_alu_op = c_ALU_XOR;
            3'b101:  f_alu_op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  f_alu_op = c_ALU_OR;
            default: f_alu_op = c_ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == S_TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`endif

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        imm_src      = c_IMM_I;
        alu_control  = c_ALU_ADD;

        // Reset gates every output so an in-flight access is dropped at once.
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    if (mem_ready) w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    // Precompute the branch/jump target into ALUOut.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (w_opcode == c_OP_JAL) ? c_IMM_J : c_IMM_B;
                    case (w_opcode)
                        c_OP_LOAD,
                        c_OP_STORE:  w_next_state = S_MEMADR;
                        c_OP_REG:    w_next_state = S_EXECR;
                        c_OP_IMM:    w_next_state = S_EXECI;
                        c_OP_BRANCH: w_next_state = S_BRANCH;
                        c_OP_JAL:    w_next_state = S_JAL;
                        c_OP_JALR:   w_next_state = S_JALR;
                        c_OP_LUI:    w_next_state = S_LUI;
                        c_OP_AUIPC:  w_next_state = S_AUIPC;
                        default:     w_next_state = c_ILLEGAL_DEST;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    if (w_opcode == c_OP_LOAD) begin
                        imm_src      = c_IMM_I;
                        w_next_state = S_MEMREAD;
                    end else begin
                        imm_src      = c_IMM_S;
                        w_next_state = S_MEMWRITE;
                    end
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) w_next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src   = 2'b01;
                    reg_write    = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) w_next_state = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a    = 2'b10;
                    alu_control  = f_alu_op(w_funct3, instr[30]);
                    w_next_state = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a    = 2'b10;
                    alu_src_b    = 2'b01;
                    // instr[30] is part of the immediate for ADDI.
                    alu_control  = f_alu_op(w_funct3, instr[30] & (w_funct3 != 3'b000));
                    w_next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write    = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_BRANCH: begin
                    // ALUOut holds the target from DECODE; ALU compares rs1/rs2.
                    alu_src_a    = 2'b10;
                    w_next_state = S_FETCH;
                    case (w_funct3)
                        3'b000: begin alu_control = c_ALU_SUB;  pc_write =  zero; end
                        3'b001: begin alu_control = c_ALU_SUB;  pc_write = !zero; end
                        3'b100: begin alu_control = c_ALU_SLT;  pc_write = !zero; end
                        3'b101: begin alu_control = c_ALU_SLT;  pc_write =  zero; end
                        3'b110: begin alu_control = c_ALU_SLTU; pc_write = !zero; end
                        3'b111: begin alu_control = c_ALU_SLTU; pc_write =  zero; end
                        default: w_next_state = c_ILLEGAL_DEST;
                    endcase
                end
                S_JAL: begin
                    // PC <- ALUOut (target) while ALU forms OldPC+4 for rd.
                    alu_src_a    = 2'b01;
                    alu_src_b    = 2'b10;
                    pc_write     = 1'b1;
                    w_next_state = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a    = 2'b10;
                    alu_src_b    = 2'b01;
                    w_next_state = S_JAL;
                end
                S_LUI: begin
                    alu_src_a    = 2'b11;
                    alu_src_b    = 2'b01;
                    imm_src      = c_IMM_U;
                    w_next_state = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a    = 2'b01;
                    alu_src_b    = 2'b01;
                    imm_src      = c_IMM_U;
                    w_next_state = S_ALUWB;
                end
                S_TRAP: begin
                    w_next_state = S_TRAP;
                end
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
//==============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A reference model
//               expands each instruction into its expected state walk
//               (including memory wait cycles) and derives the expected
//               control outputs of every cycle from the instruction semantics.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_multicycle_control;

    localparam logic [3:0] c_ADD  = 4'b0010;
    localparam logic [3:0] c_SUB  = 4'b0110;
    localparam logic [3:0] c_AND  = 4'b0000;
    localparam logic [3:0] c_OR   = 4'b0001;
    localparam logic [3:0] c_XOR  = 4'b1010;
    localparam logic [3:0] c_SLT  = 4'b0111;
    localparam logic [3:0] c_SLTU = 4'b1111;
    localparam logic [3:0] c_SLL  = 4'b1000;
    localparam logic [3:0] c_SRL  = 4'b1001;
    localparam logic [3:0] c_SRA  = 4'b0011;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic [3:0]  state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    logic exp_illegal = 1'b0;

    multicycle_control u_dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ALU op for register (is_r=1) or immediate arithmetic.
    function automatic logic [3:0] arith_op(input logic [31:0] ins, input bit is_r);
        case (ins[14:12])
            3'd0: return (is_r && ins[30]) ? c_SUB : c_ADD;
            3'd1: return c_SLL;
            3'd2: return c_SLT;
            3'd3: return c_SLTU;
            3'd4: return c_XOR;
            3'd5: return ins[30] ? c_SRA : c_SRL;
            3'd6: return c_OR;
            default: return c_AND;
        endcase
    endfunction

    function automatic bit branch_legal(input logic [31:0] ins);
        return !(ins[14:12] == 3'd2 || ins[14:12] == 3'd3);
    endfunction

    // Compare op: BEQ/BNE subtract, BLT/BGE signed less-than, BLTU/BGEU unsigned.
    function automatic logic [3:0] branch_op(input logic [31:0] ins);
        case (ins[14:13])
            2'b00:   return c_SUB;
            2'b10:   return c_SLT;
            2'b11:   return c_SLTU;
            default: return c_ADD;
        endcase
    endfunction

    // BEQ taken on equality (zero); BLT-family taken when "less" (not zero);
    // odd funct3 is the inverted condition.
    function automatic bit branch_taken(input logic [31:0] ins, input logic z);
        bit base;
        base = (ins[14:12] == 3'd0 || ins[14:12] == 3'd1) ? z : !z;
        return ins[12] ? !base : base;
    endfunction

    // Expected {alu_src_a, alu_src_b, imm_src} for a state.
    function automatic logic [6:0] exp_sel(input int s, input logic [31:0] ins);
        case (s)
            0:  return {2'b00, 2'b10, 3'd0};
            1:  return {2'b01, 2'b01, (ins[6:0] == 7'b1101111) ? 3'd3 : 3'd2};
            2:  return {2'b10, 2'b01, (ins[6:0] == 7'b0000011) ? 3'd0 : 3'd1};
            6:  return {2'b10, 2'b00, 3'd0};
            7:  return {2'b10, 2'b01, 3'd0};
            9:  return {2'b10, 2'b00, 3'd0};
            10: return {2'b01, 2'b10, 3'd0};
            11: return {2'b10, 2'b01, 3'd0};
            12: return {2'b11, 2'b01, 3'd4};
            13: return {2'b01, 2'b01, 3'd4};
            default: return 7'd0;
        endcase
    endfunction

    // One cycle in expected state s; inputs are driven just after posedge.
    task automatic run_cycle(input int s, input bit last_of_run);
        logic       mr;
        logic [3:0] e_alu;
        logic       e_pcw;
        logic [1:0] e_res;
        if (s == 0 || s == 3 || s == 5) mr = last_of_run;
        else                            mr = 1'($urandom_range(0, 1));
        mem_ready = mr;
        @(negedge clk);
        if (s == 14) exp_illegal = 1'b1;
        e_alu = c_ADD;
        if (s == 6) e_alu = arith_op(instr, 1'b1);
        if (s == 7) e_alu = arith_op(instr, 1'b0);
        if (s == 9) e_alu = branch_op(instr);
        e_pcw = (s == 0 && mr) || (s == 10) ||
                (s == 9 && branch_legal(instr) && branch_taken(instr, zero));
        e_res = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
        check("state", 32'(state), 32'(s));
        check("ctrl", {25'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write},
              {25'd0, (s == 0 || s == 3 || s == 5), (s == 5), (s == 3 || s == 5),
               (s == 0 && mr), e_pcw, (s == 4 || s == 8)});
        check("result_src", 32'(result_src), 32'(e_res));
        check("sel", 32'({alu_src_a, alu_src_b, imm_src}), 32'(exp_sel(s, instr)));
        check("alu_control", 32'(alu_control), 32'(e_alu));
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal", 32'(illegal), 32'(exp_illegal));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        mem_ready = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_ctrl", {16'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                               result_src, alu_src_a, alu_src_b, imm_src}, 32'd0);
            check("rst_alu", 32'(alu_control), 32'(c_ADD));
            @(posedge clk);
            #1;
        end
        reset       = 1'b0;
        exp_illegal = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z);
        bit bad = 0;
        int s;
        bit last;
        instr = ins;
        zero  = z;
        exp_q.delete();
        repeat (wf + 1) exp_q.push_back(0);
        exp_q.push_back(1);
        case (ins[6:0])
            7'b0000011: begin exp_q.push_back(2); repeat (wm + 1) exp_q.push_back(3); exp_q.push_back(4); end
            7'b0100011: begin exp_q.push_back(2); repeat (wm + 1) exp_q.push_back(5); end
            7'b0110011: begin exp_q.push_back(6); exp_q.push_back(8); end
            7'b0010011: begin exp_q.push_back(7); exp_q.push_back(8); end
            7'b1100011: begin exp_q.push_back(9); bad = !branch_legal(ins); end
            7'b1101111: begin exp_q.push_back(10); exp_q.push_back(8); end
            7'b1100111: begin exp_q.push_back(11); exp_q.push_back(10); exp_q.push_back(8); end
            7'b0110111: begin exp_q.push_back(12); exp_q.push_back(8); end
            7'b0010111: begin exp_q.push_back(13); exp_q.push_back(8); end
            default:    bad = 1;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (bad) repeat (4) exp_q.push_back(14);
`endif
        while (exp_q.size() > 0) begin
            s    = exp_q.pop_front();
            last = (exp_q.size() == 0) || (exp_q[0] != s);
            run_cycle(s, last);
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (bad) do_reset(1);
`endif
    endtask

    logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111, 7'b0001011, 7'b1111111};

    initial begin
        logic [31:0] rnd;
        reset     = 1'b1;
        instr     = 32'h00052583;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        do_reset(2);

        run_instr(32'h40B50533, 0, 0, 1'b0);   // sub
        run_instr(32'h00052583, 0, 3, 1'b0);   // lw, 3 wait cycles
        run_instr(32'h00B50463, 0, 0, 1'b1);   // beq taken
        run_instr(32'h00B50463, 0, 0, 1'b0);   // beq not taken
        run_instr(32'h000500E7, 0, 0, 1'b0);   // jalr

        // Reset in the middle of a load abandons the access immediately.
        instr = 32'h00052583;
        run_cycle(0, 1'b1);
        run_cycle(1, 1'b1);
        run_cycle(2, 1'b1);
        mem_ready = 1'b0;
        @(negedge clk);
        check("memreq_before_rst", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("memreq_in_rst", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 250; i++) begin
            rnd      = $urandom();
            rnd[6:0] = ops[$urandom_range(0, 10)];
            run_instr(rnd, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        run_instr(32'h0000000B, 0, 0, 1'b0);   // illegal opcode
        run_instr(32'h00B50533, 1, 0, 1'b0);   // add after illegal

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
